// File: rtl/mem_access_ahb_pkg.sv
// Shared encodings for the memory-access stage: funct3 codes, AHB transfer
// types and the stage FSM state type.
package mem_access_ahb_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;
  localparam logic [2:0] F3_BAD = 3'd7;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_ahb_lane_align.sv
// Combinational byte-lane helper: store strobes and lane replication,
// load right-shift by byte offset followed by sign/zero extension.
module mem_access_ahb_lane_align #(
  parameter int XLEN   = 64,
  parameter int NBYTES = XLEN / 8,
  parameter int OFF_W  = $clog2(NBYTES)
) (
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [NBYTES-1:0] o_strb,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_rdata
);

  logic [NBYTES-1:0] w_base;
  logic [XLEN-1:0]   w_sh;
  logic              w_sext;

  always_comb begin
    w_base = '0;
    for (int i = 0; i < NBYTES; i++) w_base[i] = (i < (1 << i_size));
    o_strb = w_base << i_offset;
  end

  always_comb begin
    case (i_size)
      2'd0:    o_wdata = {NBYTES{i_wdata[7:0]}};
      2'd1:    o_wdata = {(NBYTES / 2){i_wdata[15:0]}};
      2'd2:    o_wdata = {(NBYTES / 4){i_wdata[31:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  // Bits above the access width are filled with the sign (or zero).
  always_comb begin
    w_sh = i_rdata >> {i_offset, 3'b000};
    case (i_size)
      2'd0:    w_sext = w_sh[7]  & ~i_unsigned;
      2'd1:    w_sext = w_sh[15] & ~i_unsigned;
      2'd2:    w_sext = w_sh[31] & ~i_unsigned;
      default: w_sext = 1'b0;
    endcase
    o_rdata = w_sh;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= (8 << i_size)) o_rdata[i] = w_sext;
    end
  end

endmodule

// File: rtl/mem_access_ahb.sv
// Memory-access pipeline stage driving an AHB-lite master port, with
// wait-state handling, fault detection and branch resolution.
module mem_access_ahb
  import mem_access_ahb_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                EN,
  input  logic                LOAD,
  input  logic [2:0]          mem_para,
  input  logic [ADDR_W-1:0]   address,
  input  logic [XLEN-1:0]     value,
  input  logic [XLEN-1:0]     alu_res,
  input  logic [4:0]          rd_i,
  input  logic                write_back,
  input  logic                branch_flag_i,
  input  logic [ADDR_W-1:0]   branch_offset_i,
  input  logic [ADDR_W-1:0]   PC_i,
  input  logic [XLEN-1:0]     HRDATA,
  input  logic                HREADY,
  input  logic                HRESP,
  output logic [ADDR_W-1:0]   HADDR,
  output logic [XLEN-1:0]     HWDATA,
  output logic [XLEN/8-1:0]   HWSTRB,
  output logic                HWRITE,
  output logic [1:0]          HTRANS,
  output logic [2:0]          HSIZE,
  output logic [XLEN-1:0]     res,
  output logic [4:0]          rd_o,
  output logic                mem_write_back_en,
  output logic                take_branch,
  output logic [ADDR_W-1:0]   branch_offset_o,
  output logic [ADDR_W-1:0]   PC_o,
  output logic                busy,
  output logic                fault,
  output logic [1:0]          o_dbg_state
);

  localparam int NBYTES = XLEN / 8;
  localparam int OFF_W  = $clog2(NBYTES);

  state_t             r_state, w_state_next;
  logic               w_squash, w_illegal, w_misaligned, w_mem_go;
  logic [OFF_W-1:0]   w_off, w_mask;
  logic [NBYTES-1:0]  w_strb;
  logic [XLEN-1:0]    w_wdata, w_ldata;

  assign w_off       = address[OFF_W-1:0];
  assign o_dbg_state = r_state;

  mem_access_ahb_lane_align #(.XLEN(XLEN)) u_lane_align (
    .i_size     (mem_para[1:0]),
    .i_unsigned (mem_para[2]),
    .i_offset   (w_off),
    .i_wdata    (value),
    .i_rdata    (HRDATA),
    .o_strb     (w_strb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_ldata)
  );

  // A taken branch kills whatever instruction follows it into this stage.
  always_comb begin
    w_squash     = take_branch;
    w_illegal    = (mem_para == F3_BAD) || (!LOAD && mem_para > F3_LD) ||
                   ((XLEN == 32) && (mem_para[1:0] == 2'd3 || mem_para == F3_LWU));
    w_mask       = OFF_W'((4'd1 << mem_para[1:0]) - 4'd1);
    w_misaligned = |(w_off & w_mask);
    w_mem_go     = EN && !w_squash && !w_illegal && !w_misaligned;
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mem_go) w_state_next = ST_ADDR;
      ST_ADDR: w_state_next = ST_DATA;
      ST_DATA: if (HREADY) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HADDR <= '0; HWDATA <= '0; HWSTRB <= '0; HWRITE <= 1'b0;
      HTRANS <= HTRANS_IDLE; HSIZE <= '0; res <= '0; rd_o <= '0;
      mem_write_back_en <= 1'b0; take_branch <= 1'b0;
      branch_offset_o <= '0; PC_o <= '0; busy <= 1'b0; fault <= 1'b0;
    end else begin
      fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          PC_o            <= PC_i;
          branch_offset_o <= branch_offset_i;
          res             <= alu_res;
          take_branch     <= branch_flag_i && (alu_res == XLEN'(1)) && !w_squash;
          if (w_squash) begin
            rd_o              <= '0;
            mem_write_back_en <= 1'b0;
          end else if (EN) begin
            rd_o              <= rd_i;
            mem_write_back_en <= 1'b0;
            if (w_mem_go) begin
              HTRANS <= HTRANS_NONSEQ;
              HADDR  <= address;
              HWRITE <= !LOAD;
              HSIZE  <= {1'b0, mem_para[1:0]};
              HWSTRB <= LOAD ? '0 : w_strb;
              HWDATA <= LOAD ? '0 : w_wdata;
              busy   <= 1'b1;
            end else begin
              fault <= 1'b1;
            end
          end else begin
            rd_o              <= rd_i;
            mem_write_back_en <= write_back;
          end
        end
        ST_ADDR: begin
          HTRANS            <= HTRANS_IDLE;
          mem_write_back_en <= 1'b0;
        end
        ST_DATA: begin
          if (HREADY) begin
            busy <= 1'b0;
            if (HRESP) begin
              fault <= 1'b1;
            end else if (LOAD) begin
              res               <= w_ldata;
              mem_write_back_en <= write_back;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ahb.sv
// Directed bench for mem_access_ahb (XLEN=64): loads, stores, wait states,
// faults, branch squash and asynchronous reset during a transfer.
module tb_mem_access_ahb;

  logic        CLK, RESET, EN, LOAD, write_back, branch_flag_i, HREADY, HRESP;
  logic [2:0]  mem_para;
  logic [63:0] address, value, alu_res, branch_offset_i, PC_i, HRDATA;
  logic [4:0]  rd_i;
  logic [63:0] HADDR, HWDATA, res, branch_offset_o, PC_o;
  logic [7:0]  HWSTRB;
  logic        HWRITE, mem_write_back_en, take_branch, busy, fault;
  logic [1:0]  HTRANS, o_dbg_state;
  logic [2:0]  HSIZE;
  logic [4:0]  rd_o;

  int total = 0;
  int bad   = 0;

  mem_access_ahb #(.XLEN(64), .ADDR_W(64)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .mem_para(mem_para),
    .address(address), .value(value), .alu_res(alu_res), .rd_i(rd_i),
    .write_back(write_back), .branch_flag_i(branch_flag_i),
    .branch_offset_i(branch_offset_i), .PC_i(PC_i), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWSTRB(HWSTRB), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .res(res), .rd_o(rd_o), .mem_write_back_en(mem_write_back_en),
    .take_branch(take_branch), .branch_offset_o(branch_offset_o),
    .PC_o(PC_o), .busy(busy), .fault(fault), .o_dbg_state(o_dbg_state)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    EN = 0; LOAD = 0; mem_para = 0; address = 0; value = 0; alu_res = 0;
    rd_i = 0; write_back = 0; branch_flag_i = 0; branch_offset_i = 0;
    PC_i = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 0;
    tick();
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL reset_htrans: got %b want 00", HTRANS); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (res !== 64'h0 || rd_o !== 5'd0 || mem_write_back_en !== 1'b0)
      begin bad++; $display("FAIL reset_wb: res=%h rd=%0d wb=%b want 0", res, rd_o, mem_write_back_en); end
    total++; if (o_dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", o_dbg_state); end
    RESET = 1;
    tick();
  endtask

  task automatic test_alu_passthrough();
    alu_res = 64'h1234; rd_i = 5'd7; write_back = 1; PC_i = 64'h400; branch_offset_i = 64'h20;
    tick();
    total++; if (res !== 64'h1234 || rd_o !== 5'd7 || mem_write_back_en !== 1'b1)
      begin bad++; $display("FAIL alu_pass: res=%h rd=%0d wb=%b want 1234/7/1", res, rd_o, mem_write_back_en); end
    total++; if (PC_o !== 64'h400 || branch_offset_o !== 64'h20 || take_branch !== 1'b0)
      begin bad++; $display("FAIL alu_pc: pc=%h off=%h tb=%b want 400/20/0", PC_o, branch_offset_o, take_branch); end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_word();
    EN = 1; LOAD = 1; mem_para = 3'd2; address = 64'h1004; rd_i = 5'd3; write_back = 1;
    HRDATA = 64'h80000001_00000000;
    tick();
    total++; if (HTRANS !== 2'b10 || HADDR !== 64'h1004 || HSIZE !== 3'd2 || HWRITE !== 1'b0)
      begin bad++; $display("FAIL lw_addr: trans=%b addr=%h size=%0d wr=%b", HTRANS, HADDR, HSIZE, HWRITE); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lw_busy1: got %b want 1", busy); end
    tick();
    total++; if (HTRANS !== 2'b00 || busy !== 1'b1 || mem_write_back_en !== 1'b0)
      begin bad++; $display("FAIL lw_data: trans=%b busy=%b wb=%b want 00/1/0", HTRANS, busy, mem_write_back_en); end
    tick();
    total++; if (res !== 64'hFFFFFFFF_80000001) begin bad++; $display("FAIL lw_res: got %h want ffffffff80000001", res); end
    total++; if (busy !== 1'b0 || mem_write_back_en !== 1'b1 || rd_o !== 5'd3)
      begin bad++; $display("FAIL lw_done: busy=%b wb=%b rd=%0d want 0/1/3", busy, mem_write_back_en, rd_o); end
    idle_inputs();
    tick();
    total++; if (mem_write_back_en !== 1'b0) begin bad++; $display("FAIL lw_wb_pulse: got %b want 0", mem_write_back_en); end
  endtask

  task automatic test_store_byte();
    EN = 1; LOAD = 0; mem_para = 3'd0; address = 64'h2003; value = 64'h12345678_9ABCDEAB;
    rd_i = 5'd4; write_back = 1;
    tick();
    total++; if (HWSTRB !== 8'h08 || HWDATA !== 64'hABABABAB_ABABABAB)
      begin bad++; $display("FAIL sb_lanes: strb=%h data=%h want 08/abab..", HWSTRB, HWDATA); end
    total++; if (HWRITE !== 1'b1 || HTRANS !== 2'b10 || HSIZE !== 3'd0)
      begin bad++; $display("FAIL sb_ctrl: wr=%b trans=%b size=%0d want 1/10/0", HWRITE, HTRANS, HSIZE); end
    tick();
    total++; if (HWSTRB !== 8'h08 || HWDATA !== 64'hABABABAB_ABABABAB)
      begin bad++; $display("FAIL sb_hold: strb=%h data=%h", HWSTRB, HWDATA); end
    tick();
    total++; if (busy !== 1'b0 || mem_write_back_en !== 1'b0)
      begin bad++; $display("FAIL sb_done: busy=%b wb=%b want 0/0", busy, mem_write_back_en); end
    idle_inputs();
    tick();
  endtask

  task automatic test_wait_states();
    int n_busy;
    n_busy = 0;
    EN = 1; LOAD = 1; mem_para = 3'd3; address = 64'h4000; rd_i = 5'd9; write_back = 1;
    HRDATA = 64'h11223344_55667788; HREADY = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!busy) break;
      n_busy++;
      total++; if (HADDR !== 64'h4000 || HSIZE !== 3'd3 || mem_write_back_en !== 1'b0)
        begin bad++; $display("FAIL ld_wait_hold: addr=%h size=%0d wb=%b at cycle %0d", HADDR, HSIZE, mem_write_back_en, k); end
      if (k == 4) HREADY = 1;
    end
    total++; if (n_busy !== 5) begin bad++; $display("FAIL ld_busy_cycles: got %0d want 5", n_busy); end
    total++; if (res !== 64'h11223344_55667788 || mem_write_back_en !== 1'b1)
      begin bad++; $display("FAIL ld_res: res=%h wb=%b want 1122334455667788/1", res, mem_write_back_en); end
    idle_inputs();
    tick();
  endtask

  task automatic test_faults();
    EN = 1; LOAD = 1; mem_para = 3'd1; address = 64'h3001; write_back = 1;
    tick();
    total++; if (fault !== 1'b1 || HTRANS !== 2'b00 || mem_write_back_en !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL lh_misalign: fault=%b trans=%b wb=%b busy=%b want 1/00/0/0", fault, HTRANS, mem_write_back_en, busy); end
    idle_inputs();
    tick();
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_pulse: got %b want 0", fault); end
    EN = 1; LOAD = 0; mem_para = 3'd4; address = 64'h5000;
    tick();
    total++; if (fault !== 1'b1 || HTRANS !== 2'b00)
      begin bad++; $display("FAIL illegal_store: fault=%b trans=%b want 1/00", fault, HTRANS); end
    idle_inputs();
    tick();
    EN = 1; LOAD = 1; mem_para = 3'd2; address = 64'h10; write_back = 1; HRESP = 1;
    tick();
    total++; if (fault !== 1'b0 || HTRANS !== 2'b10)
      begin bad++; $display("FAIL lw_err_issue: fault=%b trans=%b want 0/10", fault, HTRANS); end
    tick();
    tick();
    total++; if (fault !== 1'b1 || mem_write_back_en !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL hresp: fault=%b wb=%b busy=%b want 1/0/0", fault, mem_write_back_en, busy); end
    idle_inputs();
    tick();
  endtask

  task automatic test_branch_squash();
    branch_flag_i = 1; alu_res = 64'd0; PC_i = 64'h800;
    tick();
    total++; if (take_branch !== 1'b0) begin bad++; $display("FAIL branch_not_taken: got %b want 0", take_branch); end
    alu_res = 64'd1; branch_offset_i = 64'h40;
    tick();
    total++; if (take_branch !== 1'b1 || branch_offset_o !== 64'h40 || PC_o !== 64'h800)
      begin bad++; $display("FAIL branch_taken: tb=%b off=%h pc=%h want 1/40/800", take_branch, branch_offset_o, PC_o); end
    idle_inputs();
    EN = 1; LOAD = 0; mem_para = 3'd2; address = 64'h6000; value = 64'h55; rd_i = 5'd5; write_back = 1;
    tick();
    total++; if (HTRANS !== 2'b00 || busy !== 1'b0 || rd_o !== 5'd0 || mem_write_back_en !== 1'b0 || take_branch !== 1'b0)
      begin bad++; $display("FAIL squash: trans=%b busy=%b rd=%0d wb=%b tb=%b want 00/0/0/0/0", HTRANS, busy, rd_o, mem_write_back_en, take_branch); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    EN = 1; LOAD = 1; mem_para = 3'd3; address = 64'h8008; rd_i = 5'd2; write_back = 1; HREADY = 0;
    tick();
    tick();
    total++; if (o_dbg_state !== 2'd2) begin bad++; $display("FAIL pre_reset_state: got %0d want 2", o_dbg_state); end
    #2 RESET = 0;
    #1;
    total++; if (busy !== 1'b0 || HADDR !== 64'h0 || HSIZE !== 3'd0 || mem_write_back_en !== 1'b0 || o_dbg_state !== 2'd0)
      begin bad++; $display("FAIL async_reset: busy=%b addr=%h size=%0d wb=%b st=%0d", busy, HADDR, HSIZE, mem_write_back_en, o_dbg_state); end
    idle_inputs();
    tick();
    RESET = 1;
    EN = 1; LOAD = 1; mem_para = 3'd4; address = 64'h7; rd_i = 5'd6; write_back = 1;
    HRDATA = 64'hF0AA5500_00000000;
    tick();
    total++; if (HTRANS !== 2'b10 || HSIZE !== 3'd0) begin bad++; $display("FAIL lbu_addr: trans=%b size=%0d", HTRANS, HSIZE); end
    tick();
    tick();
    total++; if (res !== 64'hF0 || mem_write_back_en !== 1'b1)
      begin bad++; $display("FAIL lbu_res: res=%h wb=%b want f0/1", res, mem_write_back_en); end
    idle_inputs();
    tick();
  endtask

  initial begin
    RESET = 0;
    idle_inputs();
    test_reset();
    test_alu_passthrough();
    test_load_word();
    test_store_byte();
    test_wait_states();
    test_faults();
    test_branch_squash();
    test_reset_mid_transfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ahb.md
Name: mem_access_ahb

Overview:
Parametrised memory-access pipeline stage with branch resolution. It sits between execute and write-back and drives an AHB-lite style master port. It adds wait-state handling (HREADY), byte-lane addressing with write strobes in place of read-modify-write, HSIZE generation, misalignment and bus-error faults, and a busy output that stalls upstream stages.

Parameters:
XLEN, 64, data/register width; 32 or 64 only
ADDR_W, 64, address width
NBYTES, XLEN/8, derived; byte lanes per beat
OFF_W, log2(NBYTES), derived; byte-offset bits

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous active-low reset
EN  in  1  instruction in this stage is a memory op
LOAD  in  1  1=load, 0=store (valid with EN)
mem_para  in  3  funct3: LB/LH/LW/LD/LBU/LHU/LWU = 0..6; stores use 0..3
address  in  ADDR_W  effective address
value  in  XLEN  store data
alu_res  in  XLEN  ALU result; non-memory result and branch condition
rd_i  in  5  destination register
write_back  in  1  instruction writes rd
branch_flag_i  in  1  instruction is a conditional branch
branch_offset_i  in  ADDR_W  branch target offset
PC_i  in  ADDR_W  instruction PC
HRDATA  in  XLEN  bus read data
HREADY  in  1  bus data phase complete
HRESP  in  1  bus error
HADDR  out  ADDR_W  bus address
HWDATA  out  XLEN  bus write data, lane-replicated
HWSTRB  out  NBYTES  byte-write strobes
HWRITE  out  1  write transfer
HTRANS  out  2  00 IDLE, 10 NONSEQ
HSIZE  out  3  log2 bytes of transfer
res  out  XLEN  result to write-back
rd_o  out  5  destination to write-back
mem_write_back_en  out  1  write-back enable
take_branch  out  1  branch taken
branch_offset_o  out  ADDR_W  registered branch offset
PC_o  out  ADDR_W  registered PC
busy  out  1  stage occupied; upstream must hold inputs
fault  out  1  one-cycle pulse: misaligned access, illegal size, or HRESP

Behaviour:
- Reset (async, RESET low): state=IDLE; all outputs 0, including HTRANS=00 and busy=0. Reset mid-transfer abandons the transfer; there is no completion pulse.
- FSM states: IDLE, ADDR, DATA.
- IDLE with no memory op, or squashed: registers outputs in one cycle.
  - res<=alu_res, rd_o<=rd_i, mem_write_back_en<=write_back, PC_o and branch_offset_o registered.
- Squash: when take_branch=1, the incoming instruction is killed. It issues no bus transfer, rd_o<=0, mem_write_back_en<=0 and take_branch<=0.
- take_branch<=1 iff branch_flag_i && alu_res==1 && not squashed.
- IDLE with EN, not squashed:
  - Check alignment: address[OFF_W-1:0] must be a multiple of 2^(mem_para[1:0]).
  - mem_para==7, store para>3, and (XLEN==32 && para[1:0]==3 or para==6) are illegal.
  - Misaligned or illegal: fault pulses, mem_write_back_en<=0, no bus transfer, stay in IDLE.
  - Otherwise go to ADDR.
- ADDR (1 cycle, busy=1):
  - HTRANS=10, HADDR=address, HWRITE=!LOAD, HSIZE=mem_para[1:0].
  - Stores: HWSTRB set for the accessed lanes at the byte offset; HWDATA holds value's low bytes replicated across all lanes.
  - Go to DATA.
- DATA (busy=1, HTRANS=00):
  - Wait while HREADY=0, holding HWDATA, HWSTRB and other address-phase info.
  - When HREADY=1 and HRESP=0, extract the load result: HRDATA >> (offset*8), then sign-extend (para 0-2) or zero-extend (para 4-6). Assert res and mem_write_back_en=write_back for exactly one cycle, then return to IDLE.
  - Stores complete with mem_write_back_en=0.
  - HREADY=1 with HRESP=1: fault pulse, no write-back, IDLE.
- busy drops in the same cycle the completion is registered.
- Upstream holds EN, LOAD, mem_para, address, value, rd_i and write_back stable while busy=1. Inputs are sampled only in IDLE.
- Branch inputs are never combined with memory ops. Branches are resolved only from IDLE.

Decomposition:
- Shared package: funct3 load/store encodings, HTRANS/HSIZE constants, FSM state typedef.
- Natural sub-module: lsu_lane_align. It is combinational and handles offset-to-strobe mapping, store replication, and load shift plus extension. It is parametrised on XLEN and unit-testable on its own.

Test Plan:
- LW at 0x1004, XLEN=64, HRDATA=0x80000001_00000000, HREADY=1 -> res=0xFFFFFFFF_80000001, HSIZE=2, 1 wait-free completion; busy high for 2 cycles.
- SB at 0x2003, value=0xAB -> HWSTRB=0x08, HWDATA=0xABABABAB_ABABABAB, HWRITE=1, mem_write_back_en=0.
- LD with HREADY low for 3 cycles -> busy=1 for 5 cycles total, HADDR and strobes stable, res valid only after HREADY.
- LH at 0x3001 -> fault pulse, HTRANS stays 00, mem_write_back_en=0. HRESP=1 on an LW -> fault, no write-back.
- Branch with alu_res=1 followed by a store -> take_branch=1, the store is squashed (no HTRANS), rd_o=0.
- RESET low during DATA -> all outputs 0 asynchronously; after release the next LBU at 0x7 with HRDATA[63:56]=0xF0 gives res=0xF0.
